// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
//   rx_state_e    : receiver FSM state encoding
//   symbol_cycles : clock cycles per bit for a given clock frequency and baud rate
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int symbol_cycles(input int clock_freq, input int baud);
    return clock_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (buttons, serial lines).
// Ports:
//   clk   : destination clock
//   rst_n : synchronous reset, active-low; both stages load RESET_VALUE
//   d     : asynchronous input
//   q     : synchronized output, two cycles of latency
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver (LSB first, idle-high) feeding a one-entry valid/ready buffer.
// Ports:
//   clk            : CPU clock
//   rst_n          : synchronous reset, active-low
//   serial_in      : asynchronous serial line, idle 1
//   data_out       : received byte, stable while data_out_valid is high
//   data_out_valid : a byte is buffered
//   data_out_ready : consumer accepts the buffered byte on valid && ready
//   framing_error  : one-cycle pulse when the stop bit is sampled low
//   overrun        : one-cycle pulse when a completed byte is dropped (buffer full)
//
// state | meaning
// IDLE  | waiting for a falling edge on an armed (previously high) line
// START | counting to mid start bit; line high there is a false start
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit; high offers the byte, low flags framing error
// BREAK | line held low after a framing error; wait for it to return high
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 10_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = symbol_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME + 1);

  localparam logic [CW-1:0] SYMBOL_TC = CW'(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] SAMPLE_TC = CW'(SAMPLE_TIME);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  if (SYMBOL_EDGE_TIME < 4) begin : g_bad_baud
    $error("uart_receiver: fewer than 4 clock cycles per bit");
  end

  logic rx;

  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (serial_in),
    .q     (rx)
  );

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    settle_q, settle_d;
  logic          armed_q, armed_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          offer;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    offer     = 1'b0;

    // The synchronizer output only reflects the pin two cycles after reset
    // release; until then its reset value of 1 must not arm the receiver,
    // otherwise a line that is low at release would look like a start edge.
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = (settle_q == 2'd2) && rx;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (armed_q && !rx) begin
          state_d = START;
          cnt_d   = CNT_ONE;
        end
      end
      START: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == SAMPLE_TC) begin
          if (rx) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DATA;
            cnt_d   = CNT_ONE;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == SYMBOL_TC) begin
          cnt_d     = CNT_ONE;
          shift_d   = {rx, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == SYMBOL_TC) begin
          cnt_d = '0;
          if (rx) begin
            offer   = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (valid_q && data_out_ready) valid_d = 1'b0;

    // An accept on the same edge frees the slot for the new byte.
    if (offer) begin
      if (!valid_q || data_out_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      settle_q  <= '0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign framing_error  = fe_q;
  assign overrun        = ov_q;

endmodule
